// File: rtl/adc_pkg.sv
// Shared definitions for the XADC scan-and-average block: FSM encoding,
// DRP addresses of the auxiliary channels and the DRP timeout counter width.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACC  = 2'd3
    } adc_state_e;

    localparam logic [6:0] VAUX5  = 7'h15;
    localparam logic [6:0] VAUX12 = 7'h1C;

    // Wide enough for any DRDY_TMO up to 256 clocks.
    localparam int TMO_W = 8;

endpackage

// File: rtl/adc_ch_avg.sv
// One channel's running sum and sample count. Every 2^AVG_LOG2 samples the
// truncated mean is latched into avg and a one-cycle avg_wr pulse follows.
module adc_ch_avg
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
)(
    input  logic        CLK12M,
    input  logic        rst,
    input  logic        acc_en,
    input  logic [11:0] sample,
    output logic [11:0] avg,
    output logic        avg_wr
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;
    logic [CNT_W-1:0] cnt_r;
    logic [11:0]      avg_r;
    logic             avg_wr_r;

    // Sum including the incoming sample; cannot exceed 4095 * 2^AVG_LOG2.
    always_comb begin
        sum_s = acc_r + ACC_W'(sample);
    end

    // Accumulate samples and emit the average on the last one of a block.
    always_ff @(posedge CLK12M) begin
        if (rst) begin
            acc_r    <= {ACC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            avg_r    <= 12'd0;
            avg_wr_r <= 1'b0;
        end else begin
            avg_wr_r <= 1'b0;
            if (acc_en) begin
                if (cnt_r == CNT_LAST) begin
                    avg_r    <= sum_s[AVG_LOG2 +: 12];
                    acc_r    <= {ACC_W{1'b0}};
                    cnt_r    <= {CNT_W{1'b0}};
                    avg_wr_r <= 1'b1;
                end else begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign avg    = avg_r;
    assign avg_wr = avg_wr_r;

endmodule

// File: rtl/adc_scan_avg.sv
// XADC sequencer: on each end-of-conversion it reads every scanned channel
// over DRP, feeds the per-channel averagers and presents one selected average.
module adc_scan_avg
    import adc_pkg::*;
#(
    parameter int               NCH          = 2,
    parameter logic [7*NCH-1:0] CH_ADDR      = {VAUX12, VAUX5},
    parameter int               AVG_LOG2     = 2,
    parameter int               CONV_DIV_BIT = 10,
    parameter int               DRDY_TMO     = 63,
    localparam int              SW           = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic          CLK12M,
    input  logic          rst,
    input  logic [SW-1:0] sel,
    input  logic          eoc_in,
    input  logic [15:0]   drp_do,
    input  logic          drp_drdy,
    output logic          convst,
    output logic          drp_den,
    output logic [6:0]    drp_daddr,
    output logic [11:0]   result,
    output logic          result_valid,
    output logic          busy,
    output logic          ovr,
    output logic          tmo
);

    localparam int              CHW      = SW;
    localparam int              NPAD     = 2 ** SW;
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRDY_TMO - 1);

    adc_state_e           state_r, state_s;
    logic [CHW-1:0]       ch_r, ch_s;
    logic [TMO_W-1:0]     tmo_cnt_r, tmo_cnt_s;
    logic [11:0]          sample_r, sample_s;
    logic                 tmo_set_s, ovr_set_s, acc_go_s;
    logic [CONV_DIV_BIT:0] conv_cnt_r;
    logic                 den_r, busy_r, ovr_r, tmo_r;
    logic [6:0]           daddr_r;
    logic [11:0]          result_r;
    logic                 result_valid_r;
    logic [NCH-1:0]       acc_en_s, avg_wr_s;
    logic [11:0]          avg_s [NCH];
    logic [11:0]          avg_pad_s [NPAD];
    logic [NPAD-1:0]      wr_pad_s;
    logic                 unused_do_s;

    // Low nibble of the DRP word is below the 12-bit ADC resolution.
    assign unused_do_s = &{1'b0, drp_do[3:0]};

    function automatic logic [6:0] ch_addr(input logic [CHW-1:0] c);
        return CH_ADDR[int'(c) * 7 +: 7];
    endfunction

    // Free-running divider whose top bit is the convert-start square wave.
    always_ff @(posedge CLK12M) begin
        if (rst) begin
            conv_cnt_r <= {(CONV_DIV_BIT + 1){1'b0}};
        end else begin
            conv_cnt_r <= conv_cnt_r + (CONV_DIV_BIT + 1)'(1);
        end
    end

    // Next-state logic for the scan FSM, including the DRP timeout.
    always_comb begin
        state_s   = state_r;
        ch_s      = ch_r;
        tmo_cnt_s = tmo_cnt_r;
        sample_s  = sample_r;
        tmo_set_s = 1'b0;
        acc_go_s  = 1'b0;
        ovr_set_s = eoc_in && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (eoc_in) begin
                    state_s = ST_REQ;
                    ch_s    = {CHW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s   = ST_WAIT;
                tmo_cnt_s = {TMO_W{1'b0}};
            end
            ST_WAIT: begin
                if (drp_drdy) begin
                    state_s  = ST_ACC;
                    sample_s = drp_do[15:4];
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s   = ST_IDLE;
                    tmo_set_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_ACC: begin
                acc_go_s = 1'b1;
                if (ch_r == CH_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    ch_s    = ch_r + CHW'(1);
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = {CHW{1'b0}};
            end
        endcase
    end

    // FSM state plus registered DRP strobes and status flags.
    always_ff @(posedge CLK12M) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ch_r      <= {CHW{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
            sample_r  <= 12'd0;
            den_r     <= 1'b0;
            daddr_r   <= CH_ADDR[6:0];
            busy_r    <= 1'b0;
            ovr_r     <= 1'b0;
            tmo_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            ch_r      <= ch_s;
            tmo_cnt_r <= tmo_cnt_s;
            sample_r  <= sample_s;
            den_r     <= (state_s == ST_REQ);
            if (state_s == ST_REQ) begin
                daddr_r <= ch_addr(ch_s);
            end
            busy_r    <= (state_s != ST_IDLE);
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end
            if (tmo_set_s) begin
                tmo_r <= 1'b1;
            end
        end
    end

    // Route the ACC-state strobe to the channel currently being scanned.
    always_comb begin
        acc_en_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            acc_en_s[i] = acc_go_s && (ch_r == CHW'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        adc_ch_avg #(
            .AVG_LOG2 (AVG_LOG2)
        ) u_ch (
            .CLK12M (CLK12M),
            .rst    (rst),
            .acc_en (acc_en_s[g]),
            .sample (sample_r),
            .avg    (avg_s[g]),
            .avg_wr (avg_wr_s[g])
        );
    end

    // Pad the average table to the full sel range; unused indices read zero.
    always_comb begin
        wr_pad_s = {NPAD{1'b0}};
        for (int i = 0; i < NPAD; i++) begin
            avg_pad_s[i] = 12'd0;
        end
        for (int i = 0; i < NCH; i++) begin
            avg_pad_s[i] = avg_s[i];
            wr_pad_s[i]  = avg_wr_s[i];
        end
    end

    // Register the selected average and its update strobe.
    always_ff @(posedge CLK12M) begin
        if (rst) begin
            result_r       <= 12'd0;
            result_valid_r <= 1'b0;
        end else begin
            result_r       <= avg_pad_s[sel];
            result_valid_r <= wr_pad_s[sel];
        end
    end

    assign convst       = conv_cnt_r[CONV_DIV_BIT];
    assign drp_den      = den_r;
    assign drp_daddr    = daddr_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign ovr          = ovr_r;
    assign tmo          = tmo_r;

endmodule

// File: tb/tb_adc_scan_avg.sv
// Scoreboard bench for adc_scan_avg: a DRP responder drives directed samples,
// expected averages and DRP addresses are queued, a monitor pops and compares.
module tb_adc_scan_avg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, eoc_in, drp_drdy, sel;
    logic [15:0] drp_do;
    logic        convst, drp_den, result_valid, busy, ovr, tmo;
    logic [6:0]  drp_daddr;
    logic [11:0] result;

    logic [1:0]  sel2;
    logic        eoc2, drdy2;
    logic [15:0] do2;
    logic        convst2_unused, den2, rv2_unused, busy2, ovr2_unused, tmo2_unused;
    logic [6:0]  daddr2;
    logic [11:0] result2;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [6:0]  addr_q[$];
    int m_acc[2];
    int m_cnt[2];

    adc_scan_avg dut (
        .CLK12M(clk), .rst(rst), .sel(sel), .eoc_in(eoc_in), .drp_do(drp_do),
        .drp_drdy(drp_drdy), .convst(convst), .drp_den(drp_den),
        .drp_daddr(drp_daddr), .result(result), .result_valid(result_valid),
        .busy(busy), .ovr(ovr), .tmo(tmo)
    );

    adc_scan_avg #(
        .NCH(3), .CH_ADDR({7'h12, 7'h11, 7'h10}), .AVG_LOG2(0),
        .CONV_DIV_BIT(3), .DRDY_TMO(63)
    ) dut2 (
        .CLK12M(clk), .rst(rst), .sel(sel2), .eoc_in(eoc2), .drp_do(do2),
        .drp_drdy(drdy2), .convst(convst2_unused), .drp_den(den2),
        .drp_daddr(daddr2), .result(result2), .result_valid(rv2_unused),
        .busy(busy2), .ovr(ovr2_unused), .tmo(tmo2_unused)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: every result_valid and every drp_den is checked against the queues.
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                bound_fail("result_valid_unexpected");
            end else begin
                chk("result_on_valid", 32'(result), 32'(exp_q.pop_front()));
            end
        end
        if (drp_den) begin
            if (addr_q.size() == 0) begin
                bound_fail("drp_den_unexpected");
            end else begin
                chk("drp_daddr", 32'(drp_daddr), 32'(addr_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic deliver(input int c, input logic [11:0] s);
        m_acc[c] += int'(s);
        m_cnt[c]++;
        if (m_cnt[c] == 4) begin
            if (int'(sel) == c) exp_q.push_back(12'(m_acc[c] >> 2));
            m_acc[c] = 0;
            m_cnt[c] = 0;
        end
    endtask

    task automatic wait_den(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drp_den) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) bound_fail("wait_drp_den");
    endtask

    task automatic wait_idle(input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) bound_fail("wait_idle");
    endtask

    // mode 0: normal, 1: eoc during ch0 WAIT, 2: no drdy on ch1, 3: rst during ch0 WAIT
    task automatic scan(input logic [11:0] s0, input logic [11:0] s1, input int mode);
        logic [11:0] smp;
        bit got;
        addr_q.push_back(7'h15);
        if (mode != 3) addr_q.push_back(7'h1C);
        @(posedge clk); #1 eoc_in = 1'b1;
        @(posedge clk); #1 eoc_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            smp = (c == 0) ? s0 : s1;
            wait_den(got);
            if (!got) return;
            @(posedge clk);
            if (mode == 2 && c == 1) begin
                wait_idle(200);
                repeat (2) @(posedge clk);
                return;
            end
            if (mode == 3) begin
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                drp_do = {smp, 4'h0};
                drp_drdy = 1'b1;
                @(posedge clk); #1 drp_drdy = 1'b0;
                return;
            end
            if (mode == 1 && c == 0) begin
                #1 eoc_in = 1'b1;
                @(posedge clk); #1 eoc_in = 1'b0;
            end
            #1 drp_do = {smp, 4'h0};
            drp_drdy = 1'b1;
            deliver(c, smp);
            @(posedge clk); #1 drp_drdy = 1'b0;
        end
        wait_idle(20);
        repeat (2) @(posedge clk);
    endtask

    task automatic scan3();
        bit got;
        @(posedge clk); #1 eoc2 = 1'b1;
        @(posedge clk); #1 eoc2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (den2) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                bound_fail("wait_den2");
                return;
            end
            @(posedge clk);
            #1 do2 = {5'd0, daddr2, 4'd0};
            drdy2 = 1'b1;
            @(posedge clk); #1 drdy2 = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy2) break;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic set_sel(input logic s);
        @(posedge clk); #1 sel = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_sel2(input logic [1:0] s);
        @(posedge clk); #1 sel2 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [11:0] t4a [4] = '{12'd8, 12'd8, 12'd8, 12'd9};
    logic [11:0] t4b [4] = '{12'd10, 12'd20, 12'd30, 12'd41};

    initial begin
        rst = 1'b1; eoc_in = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0000; sel = 1'b0;
        eoc2 = 1'b0; drdy2 = 1'b0; do2 = 16'h0000; sel2 = 2'd2;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_drp_den", 32'(drp_den), 32'd0);
        chk("rst_drp_daddr", 32'(drp_daddr), 32'h15);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_convst", 32'(convst), 32'd0);

        // convst: high during counts 1024..2047 after reset release
        repeat (1030) @(posedge clk);
        @(negedge clk);
        chk("convst_high", 32'(convst), 32'd1);
        repeat (1020) @(posedge clk);
        @(negedge clk);
        chk("convst_low", 32'(convst), 32'd0);

        // full-scale samples on both channels
        repeat (4) scan(12'hFFF, 12'hFFF, 0);
        @(negedge clk);
        chk("full_scale_avg", 32'(result), 32'd4095);

        // 100..103 on ch0 -> 101
        for (int i = 0; i < 4; i++) scan(12'(100 + i), 12'd200, 0);
        @(negedge clk);
        chk("avg_100_103", 32'(result), 32'd101);

        // fresh block: 8,8,8,9 -> 8 ; ch1 10,20,30,41 -> 25
        for (int i = 0; i < 4; i++) scan(t4a[i], t4b[i], 0);
        @(negedge clk);
        chk("avg_fresh", 32'(result), 32'd8);

        // eoc while in WAIT
        scan(12'd50, 12'd60, 1);
        @(negedge clk);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_no_tmo", 32'(tmo), 32'd0);
        scan(12'd50, 12'd64, 0);
        @(negedge clk);
        chk("ovr_sticky", 32'(ovr), 32'd1);

        // drdy withheld on ch1
        scan(12'd50, 12'd0, 2);
        @(negedge clk);
        chk("tmo_set", 32'(tmo), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        scan(12'd50, 12'd68, 0);
        @(negedge clk);
        chk("avg_after_tmo", 32'(result), 32'd50);

        // sel 0 -> 1: ch1 average appears with no strobe
        set_sel(1'b1);
        chk("sel1_result", 32'(result), 32'd25);
        chk("sel1_no_valid", 32'(result_valid), 32'd0);
        scan(12'd70, 12'd72, 0);
        @(negedge clk);
        chk("ch1_count_kept", 32'(result), 32'd66);
        set_sel(1'b0);
        chk("sel0_result", 32'(result), 32'd50);
        chk("sel0_no_valid", 32'(result_valid), 32'd0);

        // rst during WAIT, then a late drdy
        scan(12'd4, 12'd0, 3);
        @(negedge clk);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_den", 32'(drp_den), 32'd0);
        chk("mid_rst_daddr", 32'(drp_daddr), 32'h15);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovr", 32'(ovr), 32'd0);
        chk("mid_rst_tmo", 32'(tmo), 32'd0);
        chk("mid_rst_convst", 32'(convst), 32'd0);
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        repeat (4) scan(12'd4, 12'd9, 0);
        @(negedge clk);
        chk("post_rst_avg0", 32'(result), 32'd4);
        set_sel(1'b1);
        chk("post_rst_avg1", 32'(result), 32'd9);

        // three-channel instance: out-of-range sel reads zero
        scan3();
        @(negedge clk);
        chk("nch3_sel2", 32'(result2), 32'h012);
        set_sel2(2'd3);
        chk("nch3_sel3_zero", 32'(result2), 32'd0);
        set_sel2(2'd1);
        chk("nch3_sel1", 32'(result2), 32'h011);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
